// File: rtl/usb_link_arbiter.sv
// usb_link_arbiter: half-duplex D+/D- line-ownership controller.
// Grants the shared pair to the receive or transmit path and enforces the inter-packet gap.
// It also enforces the bus-turnaround timeout after a TX that expects a response.
// Optional feature macro: RX_BABBLE_GUARD_EN enables the RX length (babble) limit.
module usb_link_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned IPG_BITS     = 2,
  parameter int unsigned TURN_TIMEOUT = 18,
  parameter int unsigned MAX_RX_BITS  = 1024
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Rx_Active_In,
  input  logic Rx_Eop,
  input  logic Tx_Req,
  input  logic Expect_Resp,
  input  logic Tx_Done,
  output logic Tx_Grant,
  output logic Oe_N,
  output logic Rx_Enable,
  output logic Timeout,
  output logic Babble,
  output logic Busy
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StRx       = 3'd1;
  localparam logic [2:0] StRxGap    = 3'd2;
  localparam logic [2:0] StTx       = 3'd3;
  localparam logic [2:0] StTxGap    = 3'd4;
  localparam logic [2:0] StWaitResp = 3'd5;

  localparam int unsigned LimitA   = (IPG_BITS > TURN_TIMEOUT) ? IPG_BITS : TURN_TIMEOUT;
  localparam int unsigned MaxLimit = (LimitA > MAX_RX_BITS) ? LimitA : MAX_RX_BITS;
  localparam int unsigned TimerW   = $clog2(MaxLimit + 1);
  localparam int unsigned CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CntW-1:0]   CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [TimerW-1:0] IpgLast  = TimerW'(IPG_BITS - 1);
  localparam logic [TimerW-1:0] TurnLast = TimerW'(TURN_TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerMax = {TimerW{1'b1}};
`ifdef RX_BABBLE_GUARD_EN
  localparam logic [TimerW-1:0] RxLast   = TimerW'(MAX_RX_BITS - 1);
`endif

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [TimerW-1:0] bit_timer_q, bit_timer_d;
  logic              expect_q, expect_d;
  logic              tx_grant_q, oe_n_q, rx_enable_q, timeout_q, busy_q;
  logic              rx_enable_d, timeout_d;
  logic              bit_tick;
  logic              ipg_done;
  logic              turn_done;
`ifdef RX_BABBLE_GUARD_EN
  logic              babble_q, babble_d;
  logic              rx_too_long;
`endif

  assign bit_tick  = (clk_cnt_q == CntLast);
  // A limit of N bits is reached on the tick that would advance the timer to N.
  assign ipg_done  = bit_tick && (bit_timer_q == IpgLast);
  assign turn_done = bit_tick && (bit_timer_q == TurnLast);
`ifdef RX_BABBLE_GUARD_EN
  assign rx_too_long = bit_tick && (bit_timer_q == RxLast);
`endif

  // Next-state decode for line ownership.
  always_comb begin
    state_d   = state_q;
    expect_d  = expect_q;
    timeout_d = 1'b0;
`ifdef RX_BABBLE_GUARD_EN
    babble_d  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (Rx_Active_In) begin
          state_d = StRx;
        end else if (Tx_Req) begin
          state_d  = StTx;
          expect_d = Expect_Resp;
        end
      end
      StRx: begin
        if (Rx_Eop) begin
          state_d = StRxGap;
`ifdef RX_BABBLE_GUARD_EN
        end else if (rx_too_long) begin
          state_d  = StRxGap;
          babble_d = 1'b1;
`endif
        end
      end
      StRxGap: begin
        if (ipg_done) state_d = StIdle;
      end
      StTx: begin
        if (Tx_Done) state_d = StTxGap;
      end
      StTxGap: begin
        if (ipg_done) state_d = expect_q ? StWaitResp : StIdle;
      end
      StWaitResp: begin
        // A response starting on the timeout cycle still wins.
        if (Rx_Active_In) begin
          state_d = StRx;
        end else if (turn_done) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bit-tick divider and bit-time timer; both restart on every state change.
  always_comb begin
    clk_cnt_d   = clk_cnt_q;
    bit_timer_d = bit_timer_q;
    if (state_d != state_q) begin
      clk_cnt_d   = '0;
      bit_timer_d = '0;
    end else begin
      clk_cnt_d = bit_tick ? '0 : clk_cnt_q + 1'b1;
      if (bit_tick && (bit_timer_q != TimerMax)) bit_timer_d = bit_timer_q + 1'b1;
    end
  end

  assign rx_enable_d = (state_d == StIdle) || (state_d == StRx) || (state_d == StWaitResp);

  // State, counters and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_timer_q <= '0;
      expect_q    <= 1'b0;
      tx_grant_q  <= 1'b0;
      oe_n_q      <= 1'b1;
      rx_enable_q <= 1'b1;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_timer_q <= bit_timer_d;
      expect_q    <= expect_d;
      tx_grant_q  <= (state_d == StTx);
      oe_n_q      <= (state_d != StTx);
      rx_enable_q <= rx_enable_d;
      timeout_q   <= timeout_d;
      busy_q      <= (state_d != StIdle);
    end
  end

`ifdef RX_BABBLE_GUARD_EN
  // Babble pulse register.
  always_ff @(posedge Clk) begin
    if (Rst) babble_q <= 1'b0;
    else     babble_q <= babble_d;
  end
  assign Babble = babble_q;
`else
  assign Babble = 1'b0;
`endif

  assign Tx_Grant  = tx_grant_q;
  assign Oe_N      = oe_n_q;
  assign Rx_Enable = rx_enable_q;
  assign Timeout   = timeout_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_usb_link_arbiter.sv
// Directed bench for usb_link_arbiter: a vector table followed by multi-cycle sequences.
// Input word  : {Rst, Rx_Active_In, Rx_Eop, Tx_Req, Expect_Resp, Tx_Done}
// Output word : {Tx_Grant, Oe_N, Rx_Enable, Timeout, Babble, Busy}
module tb_usb_link_arbiter;

  logic clk = 1'b0;
  logic rst, rx_active, rx_eop, tx_req, expect_resp, tx_done;
  logic tx_grant, oe_n, rx_enable, timeout, babble, busy;

  int n_vec = 0;
  int n_bad = 0;

  // Expected output words per state.
  localparam logic [5:0] OIdle = 6'b011000;
  localparam logic [5:0] ORx   = 6'b011001;
  localparam logic [5:0] OGap  = 6'b010001;
  localparam logic [5:0] OTx   = 6'b100001;
  localparam logic [5:0] OWait = 6'b011001;
  localparam logic [5:0] OTo   = 6'b011100;
`ifdef RX_BABBLE_GUARD_EN
  localparam logic [5:0] OBab  = 6'b010011;
`endif

  typedef struct {
    logic [5:0] in;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  usb_link_arbiter #(
    .CLKS_PER_BIT(4),
    .IPG_BITS(2),
    .TURN_TIMEOUT(18),
    .MAX_RX_BITS(16)
  ) dut (
    .Clk(clk),
    .Rst(rst),
    .Rx_Active_In(rx_active),
    .Rx_Eop(rx_eop),
    .Tx_Req(tx_req),
    .Expect_Resp(expect_resp),
    .Tx_Done(tx_done),
    .Tx_Grant(tx_grant),
    .Oe_N(oe_n),
    .Rx_Enable(rx_enable),
    .Timeout(timeout),
    .Babble(babble),
    .Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] in);
    {rst, rx_active, rx_eop, tx_req, expect_resp, tx_done} = in;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {tx_grant, oe_n, rx_enable, timeout, babble, busy};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (grant,oe_n,rx_en,timeout,babble,busy)",
               name, got, exp);
    end
  endtask

  task automatic add(input logic [5:0] in, input logic [5:0] exp, input string name);
    vec_t v;
    v.in   = in;
    v.exp  = exp;
    v.name = name;
    vecs.push_back(v);
  endtask

  // Drives a TX expecting a response and stops at the first cycle of WAIT_RESP.
  task automatic to_wait_resp(input string tag);
    drive(6'b100000);
    step();
    drive(6'b000000);
    step();
    check({tag, "_idle"}, OIdle);
    drive(6'b000110);
    step();
    check({tag, "_tx"}, OTx);
    drive(6'b000001);
    step();
    check({tag, "_txgap"}, OGap);
    drive(6'b000000);
    for (int i = 1; i < 8; i++) begin
      step();
      check({tag, "_txgap_hold"}, OGap);
    end
    step();
    check({tag, "_wait_entry"}, OWait);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(6'b100000);

    // Reset, TX grant, reset mid-TX, RX-over-TX priority, RX gap, TX gap and regrant.
    add(6'b100000, OIdle, "reset_0");
    add(6'b100000, OIdle, "reset_1");
    add(6'b000100, OTx,   "grant_next_cycle");
    add(6'b010100, OTx,   "tx_ignores_rx_active");
    add(6'b001000, OTx,   "tx_ignores_rx_eop");
    add(6'b100000, OIdle, "reset_mid_tx");
    add(6'b000000, OIdle, "idle_after_reset");
    add(6'b010100, ORx,   "rx_wins_tie");
    add(6'b010101, ORx,   "rx_ignores_tx_done");
    add(6'b001100, OGap,  "rx_eop_to_gap");
    for (int i = 1; i < 8; i++) add(6'b000100, OGap, "rx_gap_no_grant");
    add(6'b000100, OIdle, "rx_gap_over");
    add(6'b000100, OTx,   "grant_after_rx_gap");
    add(6'b000001, OGap,  "tx_done_drops_grant");
    for (int i = 1; i < 8; i++) add(6'b000100, OGap, "tx_gap_no_grant");
    add(6'b000100, OIdle, "tx_gap_over");
    add(6'b000100, OTx,   "regrant_after_tx_gap");
    add(6'b000001, OGap,  "tx_done_again");

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      step();
      check(vecs[i].name, vecs[i].exp);
    end

    // Turnaround timeout with no response.
    to_wait_resp("to");
    for (int i = 1; i < 72; i++) begin
      step();
      check("wait_no_timeout_yet", OWait);
    end
    step();
    check("timeout_pulse", OTo);
    step();
    check("timeout_single_pulse", OIdle);

    // Response at cycle 40 of WAIT_RESP.
    to_wait_resp("resp");
    for (int i = 1; i < 40; i++) begin
      step();
      check("wait_before_resp", OWait);
    end
    drive(6'b010000);
    step();
    check("resp_to_rx", ORx);
    for (int i = 0; i < 60; i++) begin
      step();
      check("rx_no_timeout", ORx);
    end
    drive(6'b001000);
    step();
    check("resp_rx_eop", OGap);
    drive(6'b000000);

    // RX length limit.
    drive(6'b100000);
    step();
    drive(6'b010000);
    step();
    check("long_rx_entry", ORx);
    for (int i = 1; i < 64; i++) begin
      step();
      check("long_rx_running", ORx);
    end
    step();
`ifdef RX_BABBLE_GUARD_EN
    check("babble_pulse", OBab);
    for (int i = 1; i < 8; i++) begin
      step();
      check("babble_gap", OGap);
    end
    step();
    check("babble_gap_over", OIdle);
`else
    check("no_babble", ORx);
    for (int i = 1; i < 8; i++) begin
      step();
      check("no_babble_stays_rx", ORx);
    end
    step();
    check("no_babble_still_rx", ORx);
`endif
    drive(6'b000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
